apu_mix_sched: RTL and testbench
================================

# apu_mix_sched

Sample scheduler and shared-ROM sequencer for the APU output stage. It divides `sys.nclk` down to the output sample rate and snapshots all five channel levels on each sample tick. It then time-multiplexes one unified non-linear mixing ROM between the pulse lookup and the triangle/noise/DMC lookup, sums the two results, and hands an 8-bit sample to the audio sink over a valid/ready handshake. It sits between the channel generators and the DAC/audio FIFO, replacing the two dedicated mixer ROMs with one.

## Interface
- `DIV`, 40: sample period in `sys.nclk` cycles. Constraint: `DIV >= ROM_LAT + 5`.
- `ROM_LAT`, 1: ROM read latency in cycles (1..3). `rom_q` is valid `ROM_LAT` cycles after `rom_addr` is presented.

- `sys.nclk`  in  1  clock; all logic is on its rising edge.
- `sys.n_reset`  in  1  asynchronous active-low reset.
- `en`  in  1  tick enable; while 0, the divider holds at 0.
- `pulse0`, `pulse1`  in  4 each  pulse channel levels.
- `triangle`, `noise`  in  4 each  channel levels.
- `dmc`  in  7  DMC level.
- `rom_addr`  out  9  unified ROM address, registered.
- `rom_q`  in  8  ROM data.
- `sample`  out  8  mixed sample.
- `sample_valid`  out  1  `sample` holds an unconsumed value.
- `sample_ready`  in  1  sink accepts the sample when valid && ready.
- `overrun`  out  8  saturating count of samples overwritten before acceptance.

## Operation
- **Divider**
  - `cnt` counts 0..DIV-1 while `en` = 1.
  - Tick = (`cnt` == DIV-1) && `en`.
  - Clearing `en` resets `cnt` to 0 but does not abort a sequence already in flight.
- **Snapshot on tick:** register `psum` = pulse0 + pulse1 (5 bits, 0..30) and `tidx` = 3·triangle + 2·noise + dmc (8 bits, 0..202). Compute both at full width; there is no truncation.
- **ROM map**
  - Pulse table: `rom_addr` = {4'b0000, psum}. Only `rom_q[6:0]` is used and bit 7 is ignored.
  - TND table: `rom_addr` = {1'b1, tidx}.
- **FSM states:** IDLE, ADDR_P, ADDR_T, WAIT, SUM.
  - IDLE: on tick, go to ADDR_P.
  - ADDR_P: drive the pulse address; go to ADDR_T.
  - ADDR_T: drive the TND address; go to WAIT.
  - WAIT: capture `pq` = rom_q[6:0] in the cycle `ROM_LAT` after ADDR_P, and `tq` = rom_q in the cycle `ROM_LAT` after ADDR_T. Go to SUM once `tq` is captured.
  - SUM: `sample` <= min({2'b0, pq} + {1'b0, tq}, 255); `sample_valid` <= 1; return to IDLE.
- **Between fetches:** `rom_addr` holds its last value outside ADDR_P/ADDR_T.
- **Handshake**
  - `sample` and `sample_valid` are stable while valid && !ready.
  - Acceptance clears `sample_valid` on the next edge, unless SUM writes in that same cycle, in which case valid stays 1 and the new sample is loaded with no overrun counted.
  - If SUM writes while valid = 1 and the sink is not accepting, the new sample replaces the old one and `overrun` increments, saturating at 255.
- **Tick during a sequence:** cannot occur given the `DIV` constraint. If `DIV` is violated, the tick is ignored.

## Timing
- **Reset values:** `rom_addr` = 0, `sample` = 0, `sample_valid` = 0, `overrun` = 0, `cnt` = 0, FSM = IDLE.
- **Sequence timing, with the tick at edge T0:**
  - ADDR_P is in cycle T0+1 and ADDR_T in cycle T0+2.
  - `pq` is captured at the end of cycle T0+1+ROM_LAT; `tq` at the end of T0+2+ROM_LAT.
  - SUM is in cycle T0+3+ROM_LAT, and `sample_valid` rises at cycle T0+4+ROM_LAT.
  - With ROM_LAT = 1, latency is 5 cycles from the tick.
- **Sample rate:** one sample every `DIV` cycles while `en` = 1. The first tick comes `DIV` cycles after reset release with `en` = 1.
- **Inputs:** only the values present at the tick edge are used; later changes have no effect on that sample.
- **Asynchronous reset mid-sequence:** immediately returns all state and outputs to reset values, and any in-flight sample is discarded.

## Test plan
- **Reset:** assert `sys.n_reset` = 0 mid-WAIT -> all outputs are 0 immediately; after release with `en` = 1, the first `sample_valid` appears at cycle DIV+4 (ROM_LAT = 1).
- **Address generation:** pulse0 = pulse1 = 15, triangle = noise = 15, dmc = 127 -> `rom_addr` = 0x01E at T0+1 and 0x1CA at T0+2.
- **Sum:** ROM model returns 0x5F @ 0x01E and 0x9F @ 0x1CA, `sample_ready` = 1 -> `sample` = 0xFE, valid for exactly 1 cycle.
- **Saturation:** ROM returns 0xFF on the pulse entry (bit 7 masked) and 0xFF on TND -> `sample` = 0x7F + 0xFF = 0x17E, clamped to 0xFF.
- **Backpressure:** hold `sample_ready` = 0 across 3 sample periods -> `sample` updates each period, `sample_valid` stays 1, and `overrun` = 2. Then assert ready -> valid drops the next cycle and `overrun` holds at 2.
- **Enable:** clear `en` at `cnt` = DIV-2 -> no tick occurs; set it again -> the next tick comes DIV cycles later. Also sweep ROM_LAT = 3 -> `sample_valid` rises at T0+7.

Source files
------------

// File: rtl/apu_mix_sched.sv
// APU output-stage sample scheduler: divides nclk to the sample rate, snapshots channel
// levels, shares one mixing ROM between the pulse and TND lookups, and hands out 8-bit samples.
module apu_mix_sched #(
  parameter int DIV     = 40,
  parameter int ROM_LAT = 1
) (
  input  logic       nclk_i,
  input  logic       n_reset_i,
  input  logic       en_i,
  input  logic [3:0] pulse0_i,
  input  logic [3:0] pulse1_i,
  input  logic [3:0] triangle_i,
  input  logic [3:0] noise_i,
  input  logic [6:0] dmc_i,
  output logic [8:0] rom_addr_o,
  input  logic [7:0] rom_q_i,
  output logic [7:0] sample_o,
  output logic       sample_valid_o,
  input  logic       sample_ready_i,
  output logic [7:0] overrun_o
);

  localparam int               CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  // Cycles after the tick at which each ROM word is on rom_q_i.
  localparam logic [2:0]       PH_P     = 3'(ROM_LAT + 1);
  localparam logic [2:0]       PH_T     = 3'(ROM_LAT + 2);

  typedef enum logic [2:0] {IDLE, ADDR_P, ADDR_T, WAIT, SUM} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic [8:0]       rom_addr_q, rom_addr_d;
  logic [7:0]       sample_q, sample_d;
  logic             valid_q, valid_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [7:0]       tidx_q, pq_q, tq_q;

  logic             tick, cap_p, cap_t, sum_wr;
  logic [4:0]       psum_w;
  logic [7:0]       tidx_w;
  logic [8:0]       mix_w;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Divider stage: tick on the last count of each sample period.
  assign tick = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    if (!en_i || (cnt_q == CNT_LAST)) cnt_d = '0;
    else                              cnt_d = cnt_q + CNT_W'(1);
  end

  // Snapshot stage: full-width lookup indices from the levels present at the tick.
  assign psum_w = {1'b0, pulse0_i} + {1'b0, pulse1_i};
  assign tidx_w = {3'b0, triangle_i, 1'b0} + {4'b0, triangle_i}
                + {3'b0, noise_i, 1'b0} + {1'b0, dmc_i};

  // ROM sequencing stage. rom_addr is registered, so each address is loaded on the
  // edge that enters its state and the pulse address comes straight from the snapshot.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rom_addr_d = rom_addr_q;
    sum_wr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d    = ADDR_P;
          phase_d    = 3'd1;
          rom_addr_d = {4'b0000, psum_w};
        end
      end
      ADDR_P: begin
        state_d    = ADDR_T;
        phase_d    = phase_q + 3'd1;
        rom_addr_d = {1'b1, tidx_q};
      end
      ADDR_T: begin
        state_d = WAIT;
        phase_d = phase_q + 3'd1;
      end
      WAIT: begin
        phase_d = phase_q + 3'd1;
        if (phase_q == PH_T) state_d = SUM;
      end
      SUM: begin
        sum_wr  = 1'b1;
        state_d = IDLE;
        phase_d = 3'd0;
      end
      default: begin
        state_d = IDLE;
        phase_d = 3'd0;
      end
    endcase
  end

  // With short ROM latency the pulse word can land while still in ADDR_T.
  assign cap_p = (state_q != IDLE) && (phase_q == PH_P);
  assign cap_t = (state_q != IDLE) && (phase_q == PH_T);

  // Mix / output stage: pq_q has bit 7 forced to zero at capture.
  assign mix_w = {1'b0, pq_q} + {1'b0, tq_q};

  always_comb begin
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (valid_q && sample_ready_i) valid_d = 1'b0;
    if (sum_wr) begin
      sample_d = sat8(mix_w);
      valid_d  = 1'b1;
      if (valid_q && !sample_ready_i) ovr_d = sat_inc8(ovr_q);
    end
  end

  always_ff @(posedge nclk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= 3'd0;
      rom_addr_q <= 9'd0;
      sample_q   <= 8'd0;
      valid_q    <= 1'b0;
      ovr_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      rom_addr_q <= rom_addr_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  always_ff @(posedge nclk_i) begin
    if (state_q == IDLE && tick) tidx_q <= tidx_w;
    if (cap_p)                   pq_q   <= rom_q_i & 8'h7F;
    if (cap_t)                   tq_q   <= rom_q_i;
  end

  assign rom_addr_o     = rom_addr_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_apu_mix_sched.sv
// Directed bench for apu_mix_sched: two instances (ROM_LAT 1 and 3) share stimulus,
// each with its own ROM model.
module tb_apu_mix_sched;

  localparam int DIV = 12;

  logic       clk = 1'b0;
  logic       rst_n, en, ready;
  logic [3:0] p0, p1, tri_l, noi;
  logic [6:0] dmc;
  logic [8:0] addr_a, addr_b;
  logic [7:0] romq_a, romq_b;
  logic [7:0] smp_a, smp_b, ovr_a, ovr_b;
  logic       vld_a, vld_b;

  logic       ov_en;
  logic [7:0] ov_p, ov_t;
  logic [7:0] pipe_b [3];
  int         mcnt;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  apu_mix_sched #(.DIV(DIV), .ROM_LAT(1)) u_a (
    .nclk_i(clk), .n_reset_i(rst_n), .en_i(en),
    .pulse0_i(p0), .pulse1_i(p1), .triangle_i(tri_l), .noise_i(noi), .dmc_i(dmc),
    .rom_addr_o(addr_a), .rom_q_i(romq_a),
    .sample_o(smp_a), .sample_valid_o(vld_a), .sample_ready_i(ready), .overrun_o(ovr_a));

  apu_mix_sched #(.DIV(DIV), .ROM_LAT(3)) u_b (
    .nclk_i(clk), .n_reset_i(rst_n), .en_i(en),
    .pulse0_i(p0), .pulse1_i(p1), .triangle_i(tri_l), .noise_i(noi), .dmc_i(dmc),
    .rom_addr_o(addr_b), .rom_q_i(romq_b),
    .sample_o(smp_b), .sample_valid_o(vld_b), .sample_ready_i(ready), .overrun_o(ovr_b));

  // Pulse region returns bit 7 set plus psum; TND region returns tidx itself.
  function automatic logic [7:0] rom_fn(input logic [8:0] a);
    if (ov_en && a == 9'h01E) return ov_p;
    if (ov_en && a == 9'h1CA) return ov_t;
    if (a[8]) return a[7:0];
    return {1'b1, a[6:0]};
  endfunction

  always @(posedge clk) begin
    romq_a    <= rom_fn(addr_a);
    pipe_b[0] <= rom_fn(addr_b);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign romq_b = pipe_b[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              mcnt <= 0;
    else if (!en)            mcnt <= 0;
    else if (mcnt == DIV-1)  mcnt <= 0;
    else                     mcnt <= mcnt + 1;
  end

  typedef struct packed {
    logic [3:0] p0, p1, tr, nz;
    logic [6:0] dmc;
    logic       ov;
    logic [7:0] ovp, ovt;
    logic [8:0] pa, ta;
    logic [7:0] smp;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [3:0] a, b, c, d, input logic [6:0] e,
                              input logic o, input logic [7:0] op, ot,
                              input logic [8:0] pa, ta, input logic [7:0] s);
    vec_t v;
    v.p0 = a; v.p1 = b; v.tr = c; v.nz = d; v.dmc = e;
    v.ov = o; v.ovp = op; v.ovt = ot; v.pa = pa; v.ta = ta; v.smp = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!(en && mcnt == DIV-1) && n < 4*DIV) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4*DIV) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: no tick within %0d cycles", 4*DIV);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    p0 = v.p0; p1 = v.p1; tri_l = v.tr; noi = v.nz; dmc = v.dmc;
    ov_en = v.ov; ov_p = v.ovp; ov_t = v.ovt;
    wait_tick();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          chk($sformatf("v%0d_addr_p_a", id), 32'(addr_a), 32'(v.pa));
          chk($sformatf("v%0d_addr_p_b", id), 32'(addr_b), 32'(v.pa));
          p0 = 4'($urandom); p1 = 4'($urandom); tri_l = 4'($urandom);
          noi = 4'($urandom); dmc = 7'($urandom);
        end
        2: begin
          chk($sformatf("v%0d_addr_t_a", id), 32'(addr_a), 32'(v.ta));
          chk($sformatf("v%0d_addr_t_b", id), 32'(addr_b), 32'(v.ta));
        end
        4: chk($sformatf("v%0d_early_vld_a", id), 32'(vld_a), 32'd0);
        5: begin
          chk($sformatf("v%0d_vld_a", id), 32'(vld_a), 32'd1);
          chk($sformatf("v%0d_sample_a", id), 32'(smp_a), 32'(v.smp));
        end
        6: begin
          chk($sformatf("v%0d_vld_drop_a", id), 32'(vld_a), 32'd0);
          chk($sformatf("v%0d_early_vld_b", id), 32'(vld_b), 32'd0);
        end
        7: begin
          chk($sformatf("v%0d_vld_b", id), 32'(vld_b), 32'd1);
          chk($sformatf("v%0d_sample_b", id), 32'(smp_b), 32'(v.smp));
        end
        8: chk($sformatf("v%0d_vld_drop_b", id), 32'(vld_b), 32'd0);
        default: ;
      endcase
    end
    ov_en = 1'b0;
  endtask

  initial begin
    logic [7:0] bp_smp [3];
    logic [7:0] bp_ovr [3];
    logic       seen;
    int         n;

    rst_n = 1'b0; en = 1'b1; ready = 1'b1;
    p0 = 0; p1 = 0; tri_l = 0; noi = 0; dmc = 0;
    ov_en = 1'b0; ov_p = 0; ov_t = 0;

    vecs[0] = mk(4'd1,  4'd2,  4'd0,  4'd0,  7'd0,   1'b0, 8'h00, 8'h00, 9'h003, 9'h100, 8'd3);
    vecs[1] = mk(4'd0,  4'd0,  4'd1,  4'd1,  7'd1,   1'b0, 8'h00, 8'h00, 9'h000, 9'h106, 8'd6);
    vecs[2] = mk(4'd15, 4'd15, 4'd15, 4'd15, 7'd127, 1'b0, 8'h00, 8'h00, 9'h01E, 9'h1CA, 8'd232);
    vecs[3] = mk(4'd7,  4'd9,  4'd10, 4'd3,  7'd50,  1'b0, 8'h00, 8'h00, 9'h010, 9'h156, 8'd102);
    vecs[4] = mk(4'd15, 4'd0,  4'd0,  4'd15, 7'd100, 1'b0, 8'h00, 8'h00, 9'h00F, 9'h182, 8'd145);
    vecs[5] = mk(4'd0,  4'd0,  4'd0,  4'd0,  7'd0,   1'b0, 8'h00, 8'h00, 9'h000, 9'h100, 8'd0);
    vecs[6] = mk(4'd15, 4'd15, 4'd15, 4'd15, 7'd127, 1'b1, 8'h5F, 8'h9F, 9'h01E, 9'h1CA, 8'hFE);
    vecs[7] = mk(4'd15, 4'd15, 4'd15, 4'd15, 7'd127, 1'b1, 8'hFF, 8'hFF, 9'h01E, 9'h1CA, 8'hFF);

    repeat (2) @(negedge clk);
    chk("rst_addr_a",    32'(addr_a), 32'd0);
    chk("rst_sample_a",  32'(smp_a),  32'd0);
    chk("rst_valid_a",   32'(vld_a),  32'd0);
    chk("rst_overrun_a", 32'(ovr_a),  32'd0);
    chk("rst_valid_b",   32'(vld_b),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure: three samples with the sink stalled.
    bp_smp[0] = 8'd2; bp_smp[1] = 8'd4; bp_smp[2] = 8'd3;
    bp_ovr[0] = 8'd0; bp_ovr[1] = 8'd1; bp_ovr[2] = 8'd2;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p0 = (i == 0) ? 4'd1 : (i == 1) ? 4'd2 : 4'd0;
      p1 = p0;
      tri_l = (i == 2) ? 4'd1 : 4'd0;
      noi = 0; dmc = 0;
      wait_tick();
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 1 && i > 0) begin
          chk($sformatf("bp%0d_hold_sample", i), 32'(smp_a), 32'(bp_smp[i-1]));
          chk($sformatf("bp%0d_hold_valid", i),  32'(vld_a), 32'd1);
        end
        if (k == 6) begin
          chk($sformatf("bp%0d_sample_a", i),  32'(smp_a), 32'(bp_smp[i]));
          chk($sformatf("bp%0d_valid_a", i),   32'(vld_a), 32'd1);
          chk($sformatf("bp%0d_overrun_a", i), 32'(ovr_a), 32'(bp_ovr[i]));
        end
      end
    end
    chk("bp_sample_b",  32'(smp_b), 32'd3);
    chk("bp_valid_b",   32'(vld_b), 32'd1);
    chk("bp_overrun_b", 32'(ovr_b), 32'd2);
    ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid_a",   32'(vld_a), 32'd0);
    chk("bp_accept_valid_b",   32'(vld_b), 32'd0);
    chk("bp_accept_overrun_a", 32'(ovr_a), 32'd2);
    chk("bp_accept_overrun_b", 32'(ovr_b), 32'd2);

    // Enable: drop en one cycle before the tick, then restart.
    n = 0;
    while (mcnt != DIV-2 && n < 2*DIV) begin
      @(negedge clk);
      n++;
    end
    en = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < DIV + 6; k++) begin
      @(negedge clk);
      if (vld_a || vld_b) seen = 1'b1;
    end
    chk("en_off_no_sample", 32'(seen), 32'd0);
    en = 1'b1;
    for (int k = 1; k <= DIV + 4; k++) begin
      @(negedge clk);
      if (k == DIV + 3) chk("en_restart_early", 32'(vld_a), 32'd0);
      if (k == DIV + 4) chk("en_restart_valid", 32'(vld_a), 32'd1);
    end

    // Asynchronous reset in WAIT, then first sample after release.
    p0 = 4'd3; p1 = 4'd4; tri_l = 4'd2; noi = 4'd1; dmc = 7'd10;
    wait_tick();
    repeat (3) @(negedge clk);
    chk("pre_rst_overrun_a", 32'(ovr_a), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_addr_a",    32'(addr_a), 32'd0);
    chk("midrst_addr_b",    32'(addr_b), 32'd0);
    chk("midrst_sample_a",  32'(smp_a),  32'd0);
    chk("midrst_valid_a",   32'(vld_a),  32'd0);
    chk("midrst_overrun_a", 32'(ovr_a),  32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (vld_a || vld_b) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 1; k <= DIV + 6; k++) begin
      @(negedge clk);
      if (k < DIV + 4 && vld_a) seen = 1'b1;
      if (k == DIV + 4) begin
        chk("rel_valid_a",  32'(vld_a), 32'd1);
        chk("rel_sample_a", 32'(smp_a), 32'd25);
      end
      if (k == DIV + 5) chk("rel_early_b", 32'(vld_b), 32'd0);
      if (k == DIV + 6) begin
        chk("rel_valid_b",  32'(vld_b), 32'd1);
        chk("rel_sample_b", 32'(smp_b), 32'd25);
      end
    end
    chk("rel_no_stale_sample", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
